// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and types for the pipeline register chain.
// Stage actions are named here so every stage uses the same vocabulary.
package pipe_reg_chain_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_HOLD  = 2'd1,
        OP_CLEAR = 2'd2
    } stage_op_e;

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline register with valid bit.
// Priority per edge: reset, flush, hold, bubble, load.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    stage_op_e        op_s;
    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Resolve flush/hold/bubble into a single action; flush beats hold.
    always_comb begin
        op_s = OP_LOAD;
        if (flush) begin
            op_s = OP_CLEAR;
        end else if (hold) begin
            op_s = OP_HOLD;
        end else if (bubble) begin
            op_s = OP_CLEAR;
        end else begin
            op_s = OP_LOAD;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= RESET_VAL;
        end else begin
            case (op_s)
                OP_LOAD: begin
                    valid_r <= load_valid;
                    data_r  <= load_data;
                end
                OP_HOLD: begin
                    valid_r <= valid_r;
                    data_r  <= data_r;
                end
                OP_CLEAR: begin
                    valid_r <= 1'b0;
                    data_r  <= RESET_VAL;
                end
                default: begin
                    valid_r <= 1'b0;
                    data_r  <= RESET_VAL;
                end
            endcase
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_reg_chain.sv
// Configurable chain of pipeline registers with stall, flush and bubble control,
// plus occupancy and a saturating stall-cycle counter for debug.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = DEF_CNT_W,
    localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall_req,
    input  logic [DEPTH-1:0]       flush,
    input  logic                   cnt_clr,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [OCC_W-1:0]       occupancy,
    output logic [CNT_W-1:0]       stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0] held_s;
    logic             valid_s [DEPTH];
    logic [WIDTH-1:0] data_s  [DEPTH];
    logic [OCC_W-1:0] occ_s;
    logic [CNT_W-1:0] stall_count_r;

    // A stall in any later stage freezes every earlier stage (suffix OR).
    always_comb begin
        held_s            = {DEPTH{1'b0}};
        held_s[DEPTH-1]   = stall_req[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            held_s[k] = held_s[k+1] | stall_req[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clock      (clock),
                .reset      (reset),
                .flush      (flush[k]),
                .hold       (held_s[k]),
                .bubble     (1'b0),
                .load_valid (in_valid),
                .load_data  (in_data),
                .valid      (valid_s[k]),
                .data       (data_s[k])
            );
        end else begin : g_rest
            // Bubble when the upstream stage is frozen but this one is free.
            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clock      (clock),
                .reset      (reset),
                .flush      (flush[k]),
                .hold       (held_s[k]),
                .bubble     (held_s[k-1]),
                .load_valid (valid_s[k-1]),
                .load_data  (data_s[k-1]),
                .valid      (valid_s[k]),
                .data       (data_s[k])
            );
        end
    end

    // Pack stage registers onto the flat outputs and count valid stages.
    always_comb begin
        stage_valid = {DEPTH{1'b0}};
        stage_data  = {(DEPTH*WIDTH){1'b0}};
        occ_s       = {OCC_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            stage_valid[k]             = valid_s[k];
            stage_data[k*WIDTH +: WIDTH] = data_s[k];
            occ_s                      = occ_s + OCC_W'(valid_s[k]);
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if ((|stall_req) && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign in_ready    = reset & ~held_s[0];
    assign out_valid   = valid_s[DEPTH-1];
    assign out_data    = data_s[DEPTH-1];
    assign occupancy   = occ_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=32, DEPTH=4, CNT_W=16).
module tb_pipe_reg_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall_req;
    logic [DEPTH-1:0]       flush;
    logic                   cnt_clr;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [2:0]             occupancy;
    logic [CNT_W-1:0]       stall_count;

    int passed = 0;
    int total  = 0;

    pipe_reg_chain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush       (flush),
        .cnt_clr     (cnt_clr),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        stall_req = 4'b0000;
        flush     = 4'b0000;
        cnt_clr   = 1'b0;

        // 1. reset held low for two edges
        step();
        step();
        check("rst_valid", 128'(stage_valid), 128'h0);
        check("rst_data", stage_data, 128'h0);
        check("rst_cnt", 128'(stall_count), 128'h0);
        check("rst_ready", 128'(in_ready), 128'h0);
        check("rst_occ", 128'(occupancy), 128'h0);
        check("rst_out_valid", 128'(out_valid), 128'h0);

        // 2. streaming
        reset = 1'b1;
        #1;
        check("ready_after_rst", 128'(in_ready), 128'h1);
        in_data = 32'h11; step();
        check("stream_stage0", 128'(stage_data[31:0]), 128'h11);
        in_data = 32'h22; step();
        in_data = 32'h33; step();
        check("stream_out_early", 128'(out_valid), 128'h0);
        in_data = 32'h44; step();
        check("stream_out_11", 128'(out_data), 128'h11);
        check("stream_out_valid", 128'(out_valid), 128'h1);
        check("stream_all", stage_data,
              {32'h11, 32'h22, 32'h33, 32'h44});
        check("stream_occ4", 128'(occupancy), 128'h4);
        in_data = 32'h55; step();
        check("stream_out_22", 128'(out_data), 128'h22);
        check("stream_occ4b", 128'(occupancy), 128'h4);
        in_valid = 1'b0; in_data = 32'h0;
        step();
        check("drain_out_33", 128'(out_data), 128'h33);
        check("drain_occ3", 128'(occupancy), 128'h3);
        step();
        step();
        check("drain_out_55", 128'(out_data), 128'h55);
        check("drain_occ1", 128'(occupancy), 128'h1);
        step();
        check("drain_empty", 128'(stage_valid), 128'h0);
        check("drain_out_data", 128'(out_data), 128'h0);

        // 3. load-use stall on stage 1
        in_valid = 1'b1;
        in_data = 32'hA0; step();
        in_data = 32'hB0; step();
        in_data = 32'hC0; stall_req = 4'b0010;
        #1;
        check("stall_ready", 128'(in_ready), 128'h0);
        step();
        check("stall_valid", 128'(stage_valid), 128'h3);
        check("stall_data", stage_data, {32'h0, 32'h0, 32'hA0, 32'hB0});
        check("stall_cnt1", 128'(stall_count), 128'h1);
        stall_req = 4'b0000;
        #1;
        check("unstall_ready", 128'(in_ready), 128'h1);
        step();
        check("resume_data", stage_data, {32'h0, 32'hA0, 32'hB0, 32'hC0});
        check("resume_occ", 128'(occupancy), 128'h3);

        // 4. branch flush of stages 0 and 1
        in_data = 32'hD0; flush = 4'b0011;
        step();
        check("flush_valid", 128'(stage_valid), 128'hC);
        check("flush_data", stage_data, {32'hA0, 32'hB0, 32'h0, 32'h0});
        check("flush_occ", 128'(occupancy), 128'h2);
        flush = 4'b0000;

        // 5. stall and flush together on stage 1
        in_data = 32'hE0; step();
        in_data = 32'hF0; step();
        check("pre5_data", stage_data, {32'h0, 32'h0, 32'hE0, 32'hF0});
        in_data = 32'h99; stall_req = 4'b0010; flush = 4'b0010;
        step();
        check("sf_valid", 128'(stage_valid), 128'h1);
        check("sf_data", stage_data, {32'h0, 32'h0, 32'h0, 32'hF0});
        check("sf_cnt2", 128'(stall_count), 128'h2);
        flush = 4'b0000;

        // reset while stalled clears everything, counter included
        reset = 1'b0;
        step();
        check("rst_stall_valid", 128'(stage_valid), 128'h0);
        check("rst_stall_cnt", 128'(stall_count), 128'h0);
        check("rst_stall_ready", 128'(in_ready), 128'h0);
        reset = 1'b1; stall_req = 4'b0000;
        step();
        check("post_rst_stage0", 128'(stage_data[31:0]), 128'h99);

        // 6. counter saturation and clear
        in_valid = 1'b0; in_data = 32'h0; stall_req = 4'b1000;
        repeat (70000) @(posedge clock);
        #1;
        check("cnt_sat", 128'(stall_count), 128'hFFFF);
        check("cnt_hold_stage0", 128'(stage_data[31:0]), 128'h99);
        cnt_clr = 1'b1;
        step();
        check("cnt_clr", 128'(stall_count), 128'h0);
        cnt_clr = 1'b0;
        step();
        check("cnt_inc_after_clr", 128'(stall_count), 128'h1);
        stall_req = 4'b0000;
        step();
        check("cnt_idle", 128'(stall_count), 128'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
